// File: rtl/lcd_text_writer.sv
// ASCII stream to LCD controller transfers: char FIFO, cursor tracking, paced strobes.
// Define LCD_WRAP_CLEAR_EN to clear the screen when the cursor wraps from row 1 to row 0.
module lcd_text_writer #(
  parameter int COLS        = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 160,
  parameter int CLEAR_HOLD  = 660
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       clear_req,
  input  logic       lcd_busy,
  output logic       lcd_enable,
  output logic [9:0] lcd_bus,
  output logic       cursor_row,
  output logic [5:0] cursor_col,
  output logic [3:0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLEAR_HOLD + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [5:0] LAST = 6'(COLS - 1);
  localparam logic [9:0] CLR_CMD = 10'h001;

`ifdef LCD_WRAP_CLEAR_EN
  localparam bit WRAP_CLEAR = 1'b1;
`else
  localparam bit WRAP_CLEAR = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } state_t;

  state_t state, state_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [7:0]    head;

  logic          clear_pend, addr_pend;
  logic          row;
  logic [5:0]    col;
  logic [9:0]    bus_q;
  logic [CW-1:0] hold_cnt;

  logic take_clear, take_addr, take_char, take_nl;
  logic wrap, wrap_clr;

  assign count      = wr_ptr - rd_ptr;
  assign fifo_full  = (count == FULL);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign push       = char_valid && !fifo_full;
  assign pop        = take_char || take_nl;
  assign head       = mem[rd_ptr[AW-1:0]];

  // A wrap moves the cursor to the start of the other row.
  assign wrap     = (take_char && col == LAST) || take_nl;
  assign wrap_clr = wrap && WRAP_CLEAR && row;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= char_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    take_clear = 1'b0;
    take_addr  = 1'b0;
    take_char  = 1'b0;
    take_nl    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!lcd_busy) begin
          if (clear_pend)       take_clear = 1'b1;
          else if (addr_pend)   take_addr  = 1'b1;
          else if (!fifo_empty) begin
            if (head == 8'h0A)  take_nl    = 1'b1;
            else                take_char  = 1'b1;
          end
        end
        if (take_clear || take_addr || take_char) state_n = SEND;
      end
      SEND:    state_n = HOLD;
      HOLD:    if (hold_cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      clear_pend <= 1'b0;
      addr_pend  <= 1'b1;
      row        <= 1'b0;
      col        <= '0;
      bus_q      <= '0;
      hold_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);

      if (take_clear) begin
        clear_pend <= 1'b0;
        addr_pend  <= 1'b1;
        row        <= 1'b0;
        col        <= '0;
        bus_q      <= CLR_CMD;
      end
      if (take_addr) begin
        addr_pend <= 1'b0;
        bus_q     <= {3'b001, row, col};
      end
      if (take_char) begin
        bus_q <= {2'b10, head};
        col   <= col + 6'd1;
      end
      if (wrap) begin
        col <= '0;
        row <= ~row;
        if (!wrap_clr) addr_pend <= 1'b1;
      end
      if (clear_req || wrap_clr) clear_pend <= 1'b1;

      if (state == SEND)
        hold_cnt <= (bus_q == CLR_CMD) ? CW'(CLEAR_HOLD - 1)
                                       : CW'(HOLD_CYCLES - 1);
      else if (state == HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - CW'(1);
    end
  end

  always_comb begin
    lcd_enable = (state == SEND);
  end

  assign char_ready = !fifo_full;
  assign lcd_bus    = bus_q;
  assign cursor_row = row;
  assign cursor_col = col;
  assign fifo_level = 4'(count);

endmodule

// File: tb/tb_lcd_text_writer.sv
// Bench for lcd_text_writer: vector table, hand sequences, random stream vs model.
// Honours LCD_WRAP_CLEAR_EN in its expectations.
module tb_lcd_text_writer;

  localparam int COLS  = 16;
  localparam int DEPTH = 8;
  localparam int HOLD  = 160;
  localparam int CLR   = 660;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic       clear_req = 1'b0;
  logic       lcd_busy;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       cursor_row;
  logic [5:0] cursor_col;
  logic [3:0] fifo_level;

  logic busy_force = 1'b0;
  logic rand_busy  = 1'b0;
  logic busy_rnd   = 1'b0;

  assign lcd_busy = busy_force | (rand_busy & busy_rnd);

  lcd_text_writer #(
    .COLS(COLS), .FIFO_DEPTH(DEPTH),
    .HOLD_CYCLES(HOLD), .CLEAR_HOLD(CLR)
  ) dut (
    .clk(clk), .rst(rst),
    .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .clear_req(clear_req),
    .lcd_busy(lcd_busy), .lcd_enable(lcd_enable),
    .lcd_bus(lcd_bus), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) busy_rnd = ($urandom_range(0, 3) == 0);

  logic [9:0] sq[$];
  int         st[$];
  always @(negedge clk)
    if (lcd_enable === 1'b1) begin
      sq.push_back(lcd_bus);
      st.push_back(cyc);
    end

  int n_chk  = 0;
  int n_pass = 0;
  int max_lvl;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic check_ge(input string nm, input int act, input int lim);
    n_chk++;
    if (act >= lim) n_pass++;
    else $display("FAIL %s: got %0d want >= %0d", nm, act, lim);
  endtask

  function automatic logic [9:0] sget(input int i);
    if (i < sq.size()) return sq[i];
    return 'x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    char_valid = 1'b0;
    clear_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sq.delete();
    st.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] c);
    bit done = 0;
    bit r;
    char_valid = 1'b1;
    char_data  = c;
    for (int k = 0; k < 3000 && !done; k++) begin
      r = char_ready;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      @(negedge clk);
      if (r) done = 1;
    end
    char_valid = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic wait_n(input int n);
    int k = 0;
    while (sq.size() < n && k < 700 * (n + 1)) begin
      @(negedge clk);
      k++;
    end
    if (sq.size() < n) check("strobe_timeout", sq.size(), n);
  endtask

  typedef struct packed {
    logic [31:0]       n;
    logic [39:0][7:0]  c;
    logic [31:0]       ne;
    logic [39:0][9:0]  e;
    logic              row;
    logic [5:0]        col;
  } vec_t;

  function automatic void addc(inout vec_t v, input logic [7:0] ch);
    v.c[v.n] = ch;
    v.n++;
  endfunction

  function automatic void adde(inout vec_t v, input logic [9:0] b);
    v.e[v.ne] = b;
    v.ne++;
  endfunction

  task automatic run_vec(input string nm, input vec_t v);
    do_reset();
    max_lvl = 0;
    for (int i = 0; i < int'(v.n); i++) push(v.c[i]);
    wait_n(int'(v.ne));
    idle(CLR + 20);
    check({nm, "_count"}, sq.size(), v.ne);
    for (int i = 0; i < int'(v.ne); i++)
      check($sformatf("%s_strobe%0d", nm, i), sget(i), v.e[i]);
    check({nm, "_row"}, cursor_row, v.row);
    check({nm, "_col"}, cursor_col, v.col);
    check({nm, "_level"}, fifo_level, 0);
    check({nm, "_ready"}, char_ready, 1);
  endtask

  logic [7:0] rin[$];
  logic [9:0] rexp[$];
  int mrow, mcol;

  // Expected strobe stream for a character stream starting from reset.
  task automatic model();
    bit pend = 1;
    bit wrapped;
    mrow = 0;
    mcol = 0;
    rexp.delete();
    foreach (rin[i]) begin
      if (pend) begin
        rexp.push_back(10'(128 + 64 * mrow + mcol));
        pend = 0;
      end
      wrapped = 0;
      if (rin[i] == 8'h0A) wrapped = 1;
      else begin
        rexp.push_back({2'b10, rin[i]});
        mcol++;
        if (mcol == COLS) wrapped = 1;
      end
      if (wrapped) begin
`ifdef LCD_WRAP_CLEAR_EN
        if (mrow == 1) rexp.push_back(10'h001);
`endif
        mrow = 1 - mrow;
        mcol = 0;
        pend = 1;
      end
    end
    if (pend) rexp.push_back(10'(128 + 64 * mrow + mcol));
  endtask

  vec_t  vt[5];
  string vn[5];
  int    acc;
  bit    hit;

  initial begin
    for (int i = 0; i < 5; i++) vt[i] = '0;
    vn[0] = "hi";
    addc(vt[0], 8'h48); addc(vt[0], 8'h49);
    adde(vt[0], 10'h080); adde(vt[0], 10'h248); adde(vt[0], 10'h249);
    vt[0].row = 0; vt[0].col = 2;

    vn[1] = "wrap17";
    for (int i = 0; i < 17; i++) addc(vt[1], 8'h41);
    adde(vt[1], 10'h080);
    for (int i = 0; i < 16; i++) adde(vt[1], 10'h241);
    adde(vt[1], 10'h0C0); adde(vt[1], 10'h241);
    vt[1].row = 1; vt[1].col = 1;

    vn[2] = "newline";
    addc(vt[2], 8'h41); addc(vt[2], 8'h0A); addc(vt[2], 8'h42);
    adde(vt[2], 10'h080); adde(vt[2], 10'h241);
    adde(vt[2], 10'h0C0); adde(vt[2], 10'h242);
    vt[2].row = 1; vt[2].col = 1;

    vn[3] = "dblnl";
    addc(vt[3], 8'h0A); addc(vt[3], 8'h0A); addc(vt[3], 8'h43);
    adde(vt[3], 10'h080); adde(vt[3], 10'h0C0);
`ifdef LCD_WRAP_CLEAR_EN
    adde(vt[3], 10'h001);
`endif
    adde(vt[3], 10'h080); adde(vt[3], 10'h243);
    vt[3].row = 0; vt[3].col = 1;

    vn[4] = "wrap33";
    for (int i = 0; i < 33; i++) addc(vt[4], 8'h42);
    adde(vt[4], 10'h080);
    for (int i = 0; i < 16; i++) adde(vt[4], 10'h242);
    adde(vt[4], 10'h0C0);
    for (int i = 0; i < 16; i++) adde(vt[4], 10'h242);
`ifdef LCD_WRAP_CLEAR_EN
    adde(vt[4], 10'h001);
`endif
    adde(vt[4], 10'h080); adde(vt[4], 10'h242);
    vt[4].row = 0; vt[4].col = 1;

    // Reset state and stall while the controller is busy
    busy_force = 1'b1;
    do_reset();
    check("rst_enable", lcd_enable, 0);
    check("rst_bus", lcd_bus, 0);
    check("rst_row", cursor_row, 0);
    check("rst_col", cursor_col, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", char_ready, 1);
    push(8'h58);
    idle(50);
    check("busy_nostrobe", sq.size(), 0);
    busy_force = 1'b0;
    wait_n(2);
    check("busy_first", sget(0), 10'h080);
    check("busy_second", sget(1), 10'h258);
    if (st.size() >= 2) check("busy_period", st[1] - st[0], HOLD + 2);
    else check("busy_period", st.size(), 2);

    for (int i = 0; i < 5; i++) begin
      run_vec(vn[i], vt[i]);
      if (i == 1) check("wrap17_maxlvl", max_lvl, DEPTH);
    end

    // FIFO full with the controller stalled
    busy_force = 1'b1;
    do_reset();
    acc = 0;
    char_valid = 1'b1;
    char_data = 8'h50;
    for (int k = 0; k < 12; k++) begin
      hit = char_ready;
      @(negedge clk);
      if (hit) begin
        acc++;
        char_data = 8'(8'h50 + acc);
      end
    end
    char_valid = 1'b0;
    check("full_accepted", acc, DEPTH);
    check("full_level", fifo_level, DEPTH);
    check("full_ready", char_ready, 0);
    busy_force = 1'b0;
    wait_n(9);
    idle(HOLD + 20);
    check("full_count", sq.size(), 9);
    check("full_addr", sget(0), 10'h080);
    for (int i = 0; i < 8; i++)
      check($sformatf("full_char%0d", i), sget(i + 1), 10'(10'h250 + i));

    // Clear request during HOLD with characters queued
    do_reset();
    push(8'h41); push(8'h42); push(8'h43);
    wait_n(1);
    idle(5);
    clear_req = 1'b1; @(negedge clk); clear_req = 1'b0;
    idle(3);
    clear_req = 1'b1; @(negedge clk); clear_req = 1'b0;
    wait_n(2);
    check("clr_cmd", sget(1), 10'h001);
    check("clr_row", cursor_row, 0);
    check("clr_col", cursor_col, 0);
    wait_n(6);
    idle(CLR + 20);
    check("clr_count", sq.size(), 6);
    check("clr_s0", sget(0), 10'h080);
    check("clr_s2", sget(2), 10'h080);
    check("clr_s3", sget(3), 10'h241);
    check("clr_s4", sget(4), 10'h242);
    check("clr_s5", sget(5), 10'h243);
    if (st.size() >= 3) begin
      check("clr_gap_hold", st[1] - st[0], HOLD + 2);
      check("clr_gap_clear", st[2] - st[1], CLR + 2);
    end
    check("clr_end_col", cursor_col, 3);

    // Reset in HOLD discards the queue
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(8'h44 + i));
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      if (lcd_enable && lcd_bus == 10'h244) hit = 1;
    end
    check("abort_send_seen", hit, 1);
    check("abort_level_pre", fifo_level, 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_enable", lcd_enable, 0);
    check("abort_level", fifo_level, 0);
    check("abort_ready", char_ready, 1);
    sq.delete();
    st.delete();
    wait_n(1);
    idle(HOLD + 20);
    check("abort_count", sq.size(), 1);
    check("abort_first", sget(0), 10'h080);

    // Random stream with random busy against the model
    rin.delete();
    for (int i = 0; i < 40; i++)
      rin.push_back(($urandom_range(0, 5) == 0) ? 8'h0A
                    : 8'($urandom_range(32, 126)));
    model();
    rand_busy = 1'b1;
    do_reset();
    foreach (rin[i]) begin
      idle($urandom_range(0, 2));
      push(rin[i]);
    end
    wait_n(rexp.size());
    idle(CLR + 20);
    rand_busy = 1'b0;
    check("rnd_count", sq.size(), rexp.size());
    foreach (rexp[i]) check($sformatf("rnd_strobe%0d", i), sget(i), rexp[i]);
    for (int i = 1; i < st.size(); i++)
      check_ge($sformatf("rnd_gap%0d", i), st[i] - st[i-1],
               (sq[i-1] == 10'h001 ? CLR : HOLD) + 2);
    check("rnd_row", cursor_row, 1'(mrow));
    check("rnd_col", cursor_col, 6'(mcol));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lcd_text_writer.md
Name: lcd_text_writer

Overview:
- Upstream feeder for the LCD controller.
- Accepts a stream of ASCII characters through a valid/ready interface and buffers them in a small FIFO.
- Tracks the cursor position on a 2-row display and converts characters into controller transfers (lcd_enable plus 10-bit lcd_bus), including DDRAM address commands at line wraps, newlines and clears.
- Paces transfers with hold counters because the controller's busy output is only a one-cycle acknowledge.

Parameters:
- COLS, 16, characters per display row (1..64).
- FIFO_DEPTH, 8, character FIFO entries (power of 2, ≥2).
- HOLD_CYCLES, 160, wait after any non-clear transfer before the next one (≥ controller's 150-cycle transfer window).
- CLEAR_HOLD, 660, wait after a clear-display transfer.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- char_valid  in  1  character offered
- char_data  in  8  ASCII code; 0x0A = newline
- char_ready  out  1  FIFO can accept; equals !fifo_full
- clear_req  in  1  single-cycle pulse: clear display, home cursor
- lcd_busy  in  1  busy from controller
- lcd_enable  out  1  single-cycle transfer strobe to controller
- lcd_bus  out  10  {rs, rw, data[7:0]} to controller
- cursor_row  out  1  current row
- cursor_col  out  6  current column, 0..COLS-1
- fifo_level  out  4  entries held, 0..FIFO_DEPTH

Behaviour:
- Reset is synchronous and active-high; all state clears on the rst clock edge.
- Reset values: lcd_enable=0, lcd_bus=0, cursor_row=0, cursor_col=0, fifo_level=0, char_ready=1, FIFO empty, FSM=IDLE, clear_pend=0, addr_pend=1. addr_pend=1 means the first transfer after reset is 0x080.
- FIFO push: char_valid && char_ready. Simultaneous push and pop leaves fifo_level unchanged. When full, char_ready=0 and char_valid is ignored; no overwrite.
- clear_req sets the sticky clear_pend flag. A repeated pulse while pending is absorbed.
- FSM states:
  - IDLE: wait until lcd_busy==0 and any action is pending. Priority is clear_pend, then addr_pend, then FIFO non-empty. Load lcd_bus per the selected action, go to SEND.
  - SEND: lcd_enable=1 for exactly one cycle with lcd_bus stable. Load the hold counter with CLEAR_HOLD if the transfer was a clear, otherwise HOLD_CYCLES. Go to HOLD.
  - HOLD: lcd_enable=0, lcd_bus held. Decrement to 0, then go to IDLE. The minimum period between strobes is hold+2 cycles.
- Action encodings and effects:
  - Clear: lcd_bus=0x001. Clears clear_pend, sets row=0, col=0, sets addr_pend=1.
  - Address: lcd_bus = {2'b00, 1, row, 6'(col)}, i.e. 0x80 | (row?0x40:0) | col. Clears addr_pend.
  - Printable char (FIFO head ≠ 0x0A): pop, lcd_bus={2'b10, char}, col+1.
    - If col reaches COLS: col=0, row toggles (row 1 wraps to row 0), addr_pend=1.
  - Newline (head = 0x0A): pop, no strobe for the character itself, col=0, row toggles, addr_pend=1. The address command then follows via the normal priority.
- clear_req arriving during HOLD is served at the next IDLE, ahead of any queued characters. The FIFO is not flushed by clear.
- lcd_busy==1 in IDLE stalls indefinitely (controller initialisation). lcd_busy is ignored in SEND and HOLD.
- rst during SEND or HOLD aborts immediately: lcd_enable drops in the same reset cycle and the FIFO is discarded.
- Counter width is clog2(CLEAR_HOLD+1). The column counter saturates logic at COLS-1 before wrap; it never holds a value ≥ COLS.

Optional Feature:
- Macro: LCD_WRAP_CLEAR_EN.
- Defined: when a wrap or newline moves the cursor from row 1 to row 0, the block sets clear_pend instead of addr_pend. The screen is therefore cleared (0x001, CLEAR_HOLD) before writing continues at 0x080.
- Undefined: the wrap issues only address 0x080 and old text is overwritten in place.

Test Plan:
- Reset, lcd_busy=1 for 50 cycles then 0 -> no strobe while busy. First strobe is lcd_bus=0x080, then the next strobe occurs exactly HOLD_CYCLES+2 cycles later.
- Push "HI" (0x48, 0x49) after reset -> strobes 0x080, 0x248, 0x249. cursor_col=2, fifo_level returns to 0.
- Push 17 'A' (0x41) with COLS=16 -> 0x080, 16× 0x241, 0x0C0, 0x241. Ends with row=1, col=1. char_ready drops while fifo_level=8.
- Push 0x41, 0x0A, 0x42 -> 0x080, 0x241, 0x0C0, 0x242. The 0x0A is never driven onto lcd_bus.
- clear_req pulse during HOLD with 3 chars queued -> next strobes 0x001, then after CLEAR_HOLD+2 cycles 0x080, then the queued chars. Cursor resets to 0,0.
- rst asserted one cycle after a SEND, with 4 chars queued -> the following cycle shows lcd_enable=0, fifo_level=0, char_ready=1. The next strobe is 0x080.
